// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg
//   Shared types for the pipeline hazard controller.
//   Gr          : architectural register number (r0..r31).
//   hz_state_e  : sequencing state of the hazard controller.
package hazard_ctrl_pkg;

    localparam int HZ_GR_W = 5;

    typedef logic [HZ_GR_W-1:0] Gr;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MC_WAIT  = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_load_use_detect.sv
// load_use_detect
//   Pure combinational load-use comparator. Flags lu when the instruction in
//   ID reads a register that a load currently in EX will write. r0 never
//   matches because it is hard-wired to zero.
// Ports:
//   id_valid, rj_no/rk_no/rd_no, use_rj/use_rk/use_rd : ID instruction operands
//   ex_valid, rd_no_ex, regWriteEn_ex, memRead_ex     : EX instruction info
//   lu                                                : load-use hazard
module load_use_detect #(
    parameter int GR_W = 5
) (
    input  logic            id_valid,
    input  logic [GR_W-1:0] rj_no,
    input  logic [GR_W-1:0] rk_no,
    input  logic [GR_W-1:0] rd_no,
    input  logic            use_rj,
    input  logic            use_rk,
    input  logic            use_rd,
    input  logic            ex_valid,
    input  logic [GR_W-1:0] rd_no_ex,
    input  logic            regWriteEn_ex,
    input  logic            memRead_ex,
    output logic            lu
);

    logic ex_load;
    logic src_hit;

    assign ex_load = ex_valid & regWriteEn_ex & memRead_ex & (rd_no_ex != '0);
    assign src_hit = (use_rj & (rj_no == rd_no_ex))
                   | (use_rk & (rk_no == rd_no_ex))
                   | (use_rd & (rd_no == rd_no_ex));
    assign lu      = id_valid & ex_load & src_hit;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Hazard sequencer for the 5-stage pipeline. Handles load-use, multi-cycle
//   EX ops, MEM data-bus waits and EX branch redirects, and counts stall cycles.
// Ports:
//   aclk, aresetn                  : clock, async active-low reset
//   id_*/ *_id                     : ID operand info for load-use detection
//   ex_valid, rd_no_ex, regWriteEn_ex, memRead_ex : EX instruction info
//   ex_mc_start / ex_mc_finish     : multi-cycle op launch / result pulses
//   ex_redirect                    : EX branch redirect request
//   mem_req / mem_ready            : MEM data-bus request / completion
//   stall_if/id/ex/mem             : hold stage registers
//   bubble_ex / bubble_mem         : insert NOP into ID/EX, EX/MEM
//   flush_id                       : squash IF/ID
//   ex_hold                        : forwarding keeps latched EX operands
//   stall_cycles                   : saturating count of stall_if cycles
//   dbg_state                      : current sequencing state
// Handshake: mem_req/mem_ready is a valid/ready pair; a request completes in
//   the cycle where both are high. mem_req stays high until that cycle.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int PERF_W = 32,
    parameter int GR_W   = 5
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              id_valid,
    input  logic [GR_W-1:0]   rj_no_id,
    input  logic [GR_W-1:0]   rk_no_id,
    input  logic [GR_W-1:0]   rd_no_id,
    input  logic              use_rj_id,
    input  logic              use_rk_id,
    input  logic              use_rd_id,
    input  logic              ex_valid,
    input  logic [GR_W-1:0]   rd_no_ex,
    input  logic              regWriteEn_ex,
    input  logic              memRead_ex,
    input  logic              ex_mc_start,
    input  logic              ex_mc_finish,
    input  logic              ex_redirect,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              stall_if,
    output logic              stall_id,
    output logic              stall_ex,
    output logic              stall_mem,
    output logic              bubble_ex,
    output logic              bubble_mem,
    output logic              flush_id,
    output logic              ex_hold,
    output logic [PERF_W-1:0] stall_cycles,
    output hz_state_e         dbg_state
);

    hz_state_e         state;
    logic              mc_done;   // mc result arrived while waiting on memory
    logic              from_mc;   // MEM_WAIT was entered with an mc op pending
    logic [PERF_W-1:0] stall_cnt;

    logic lu;
    logic mem_stall_req;
    logic mc_hold;
    logic mem_st;
    logic mc_st;
    logic stall_ex_i;
    logic stall_if_i;

    load_use_detect #(.GR_W(GR_W)) u_lu (
        .id_valid     (id_valid),
        .rj_no        (rj_no_id),
        .rk_no        (rk_no_id),
        .rd_no        (rd_no_id),
        .use_rj       (use_rj_id),
        .use_rk       (use_rk_id),
        .use_rd       (use_rd_id),
        .ex_valid     (ex_valid),
        .rd_no_ex     (rd_no_ex),
        .regWriteEn_ex(regWriteEn_ex),
        .memRead_ex   (memRead_ex),
        .lu           (lu)
    );

    assign mem_stall_req = mem_req & ~mem_ready;

    // The cycle mem_ready arrives lets MEM advance, so a request that waited
    // N cycles with mem_ready low costs exactly N stall cycles.
    assign mem_st = (mem_req | (state == MEM_WAIT)) & ~mem_ready;

    // An mc op is still outstanding in MC_WAIT, and also in MEM_WAIT when we
    // came from MC_WAIT; this keeps EX held in the mem_ready cycle.
    assign mc_hold = (state == MC_WAIT) | ((state == MEM_WAIT) & from_mc);
    assign mc_st   = (mc_hold & ~ex_mc_finish & ~mc_done)
                   | (ex_mc_start & ~ex_mc_finish);

    assign stall_ex_i = mem_st | mc_st;
    assign stall_if_i = aresetn & (stall_ex_i | lu);

    // All controls are forced low while reset is asserted.
    assign stall_mem  = aresetn & mem_st;
    assign stall_ex   = aresetn & stall_ex_i;
    assign ex_hold    = aresetn & stall_ex_i;
    assign stall_if   = stall_if_i;
    assign stall_id   = stall_if_i;
    assign bubble_mem = aresetn & mc_st & ~mem_st;
    assign bubble_ex  = aresetn & lu & ~stall_ex_i;
    // A redirect under an EX stall is dropped; EX presents it again later.
    assign flush_id   = aresetn & ex_redirect & ex_valid & ~stall_ex_i;

    assign stall_cycles = stall_cnt;
    assign dbg_state    = state;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state   <= RUN;
            mc_done <= 1'b0;
            from_mc <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_stall_req) begin
                        state   <= MEM_WAIT;
                        from_mc <= 1'b0;
                    end else if (ex_mc_start & ~ex_mc_finish) begin
                        state <= MC_WAIT;
                    end
                end
                MC_WAIT: begin
                    if (mem_stall_req) begin
                        state   <= MEM_WAIT;
                        from_mc <= 1'b1;
                        mc_done <= ex_mc_finish;
                    end else if (ex_mc_finish | mc_done) begin
                        state   <= RUN;
                        mc_done <= 1'b0;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        from_mc <= 1'b0;
                        if (from_mc & ~mc_done & ~ex_mc_finish) begin
                            state <= MC_WAIT;
                        end else begin
                            // Any return to RUN leaves no pending mc result.
                            state   <= RUN;
                            mc_done <= 1'b0;
                        end
                    end else if (ex_mc_finish) begin
                        mc_done <= 1'b1;
                    end
                end
                default: begin
                    state   <= RUN;
                    mc_done <= 1'b0;
                    from_mc <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            stall_cnt <= '0;
        end else if (stall_if_i && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule
